// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - bundle of both master ports and the RAM port of mem_port_arbiter
interface mem_port_arbiter_if;
    logic        m0_req;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic [3:0]  m0_wmask;
    logic        m0_gnt;
    logic        m0_rvalid;
    logic [31:0] m0_rdata;

    logic        m1_req;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [3:0]  m1_wmask;
    logic        m1_gnt;
    logic        m1_rvalid;
    logic [31:0] m1_rdata;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rstrb;
    logic [31:0] mem_rdata;

    // Arbiter side: sees requests and RAM read data, drives grants and the RAM port.
    modport slave (
        input  m0_req, m0_addr, m0_wdata, m0_wmask,
        input  m1_req, m1_addr, m1_wdata, m1_wmask,
        input  mem_rdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_addr, mem_wdata, mem_wmask, mem_rstrb
    );

    // Requester/RAM side: the mirror image of the arbiter view.
    modport master (
        output m0_req, m0_addr, m0_wdata, m0_wmask,
        output m1_req, m1_addr, m1_wdata, m1_wmask,
        output mem_rdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_addr, mem_wdata, mem_wmask, mem_rstrb
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-master single-port RAM arbiter, bounded-burst round-robin (ARB_FIXED_PRIO_EN selects fixed m0 priority)
module mem_port_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                resetn,
    mem_port_arbiter_if.slave   bus
);

    logic rd_pend_q, rd_pend_d;
    logic rd_who_q,  rd_who_d;

    logic gnt0, gnt1, gnt_any, gnt_rd;

`ifndef ARB_FIXED_PRIO_EN
    localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

    logic       owner_q, owner_d;
    logic [3:0] burst_cnt_q, burst_cnt_d;
    logic       keep_owner;
    logic       winner;
`endif

    // Choose at most one master per cycle; nothing is granted while in reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
        // A zero count means the previous cycle was idle, so there is no burst
        // to continue and contention goes to the master not granted last.
        keep_owner = (burst_cnt_q != 4'd0) && (burst_cnt_q < MAX_BURST_C);
        winner     = keep_owner ? owner_q : ~owner_q;
`endif
        if (resetn) begin
            if (bus.m0_req && bus.m1_req) begin
`ifdef ARB_FIXED_PRIO_EN
                gnt0 = 1'b1;
`else
                gnt0 = ~winner;
                gnt1 = winner;
`endif
            end else begin
                gnt0 = bus.m0_req;
                gnt1 = bus.m1_req;
            end
        end
    end

    // Steer the granted master onto the RAM port and route read data back.
    always_comb begin
        bus.mem_addr  = 32'd0;
        bus.mem_wdata = 32'd0;
        bus.mem_wmask = 4'd0;
        if (gnt0) begin
            bus.mem_addr  = bus.m0_addr;
            bus.mem_wdata = bus.m0_wdata;
            bus.mem_wmask = bus.m0_wmask;
        end else if (gnt1) begin
            bus.mem_addr  = bus.m1_addr;
            bus.mem_wdata = bus.m1_wdata;
            bus.mem_wmask = bus.m1_wmask;
        end
        gnt_any       = gnt0 | gnt1;
        gnt_rd        = gnt_any & (bus.mem_wmask == 4'd0);
        bus.mem_rstrb = gnt_rd;
        bus.m0_gnt    = gnt0;
        bus.m1_gnt    = gnt1;
        // Gating with resetn cancels a read that was in flight when reset hit.
        bus.m0_rvalid = resetn & rd_pend_q & ~rd_who_q;
        bus.m1_rvalid = resetn & rd_pend_q &  rd_who_q;
        bus.m0_rdata  = bus.m0_rvalid ? bus.mem_rdata : 32'd0;
        bus.m1_rdata  = bus.m1_rvalid ? bus.mem_rdata : 32'd0;
    end

    // Next-state for the read tracker and the burst bookkeeping.
    always_comb begin
        rd_pend_d = gnt_rd;
        rd_who_d  = gnt_rd ? gnt1 : rd_who_q;
`ifndef ARB_FIXED_PRIO_EN
        owner_d     = owner_q;
        burst_cnt_d = 4'd0;
        if (gnt_any) begin
            if (gnt1 == owner_q) begin
                burst_cnt_d = (burst_cnt_q == 4'hF) ? 4'hF : burst_cnt_q + 4'd1;
            end else begin
                owner_d     = gnt1;
                burst_cnt_d = 4'd1;
            end
        end
`endif
    end

    // State registers; owner resets to m1 so m0 wins the first contention.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_pend_q   <= 1'b0;
            rd_who_q    <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            owner_q     <= 1'b1;
            burst_cnt_q <= 4'd0;
`endif
        end else begin
            rd_pend_q   <= rd_pend_d;
            rd_who_q    <= rd_who_d;
`ifndef ARB_FIXED_PRIO_EN
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int MAX_BURST = 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.MAX_BURST(MAX_BURST)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'hDEADBEEF;
        return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
    endfunction

    // RAM environment: one-cycle registered read, byte-masked write.
    logic        init_ram = 1'b1;
    logic [31:0] ram [16];
    always @(posedge clk) begin
        if (init_ram) begin
            for (int i = 0; i < 16; i++) ram[i] <= init_word(i);
        end else begin
            if (bus.mem_rstrb) bus.mem_rdata <= ram[bus.mem_addr[5:2]];
            for (int b = 0; b < 4; b++)
                if (bus.mem_wmask[b]) ram[bus.mem_addr[5:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end
    end

    // Reference model state.
    logic [31:0] shadow [16];
    int          last = 1;
    int          streak = 0;
    bit          pend = 0;
    int          pend_who = 0;
    logic [31:0] pend_data = 32'd0;

    // Master stimulus state.
    bit          mreq   [2];
    logic [31:0] maddr  [2];
    logic [31:0] mwdata [2];
    logic [3:0]  mwmask [2];

    task automatic drive();
        bus.m0_req   = mreq[0];   bus.m1_req   = mreq[1];
        bus.m0_addr  = maddr[0];  bus.m1_addr  = maddr[1];
        bus.m0_wdata = mwdata[0]; bus.m1_wdata = mwdata[1];
        bus.m0_wmask = mwmask[0]; bus.m1_wmask = mwmask[1];
    endtask

    task automatic set_req(input int m, input logic [31:0] a, input logic [31:0] d, input logic [3:0] k);
        mreq[m] = 1'b1; maddr[m] = a; mwdata[m] = d; mwmask[m] = k;
    endtask

    task automatic new_req(input int m, input bit rd_only);
        logic [3:0] w;
        w = 4'($urandom_range(0, 15));
        mreq[m]   = 1'b1;
        maddr[m]  = {26'd0, w, 2'b00};
        mwdata[m] = $urandom;
        mwmask[m] = (rd_only || $urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
    endtask

    // One clock: apply inputs, compare at negedge against the model, advance the model.
    task automatic step(output int g, output int gd);
        logic [31:0] ea, ew;
        logic [3:0]  em;
        bit          rv0, rv1;
        logic [3:0]  idx;
        drive();
        @(negedge clk);
        g = -1;
        if (resetn) begin
            if (mreq[0] && mreq[1]) begin
`ifdef ARB_FIXED_PRIO_EN
                g = 0;
`else
                g = (streak > 0 && streak < MAX_BURST) ? last : 1 - last;
`endif
            end else if (mreq[0]) g = 0;
            else if (mreq[1]) g = 1;
        end
        ea = 32'd0; ew = 32'd0; em = 4'd0;
        if (g >= 0) begin ea = maddr[g]; ew = mwdata[g]; em = mwmask[g]; end
        rv0 = resetn && pend && pend_who == 0;
        rv1 = resetn && pend && pend_who == 1;
        gd = bus.m1_gnt ? 1 : (bus.m0_gnt ? 0 : -1);
        check("m0_gnt",    32'(bus.m0_gnt),    32'(g == 0));
        check("m1_gnt",    32'(bus.m1_gnt),    32'(g == 1));
        check("mem_addr",  bus.mem_addr,       ea);
        check("mem_wdata", bus.mem_wdata,      ew);
        check("mem_wmask", 32'(bus.mem_wmask), 32'(em));
        check("mem_rstrb", 32'(bus.mem_rstrb), 32'(g >= 0 && em == 4'd0));
        check("m0_rvalid", 32'(bus.m0_rvalid), 32'(rv0));
        check("m1_rvalid", 32'(bus.m1_rvalid), 32'(rv1));
        check("m0_rdata",  bus.m0_rdata,       rv0 ? pend_data : 32'd0);
        check("m1_rdata",  bus.m1_rdata,       rv1 ? pend_data : 32'd0);
        if (!resetn) begin
            last = 1; streak = 0; pend = 0;
        end else if (g < 0) begin
            streak = 0; pend = 0;
        end else begin
            if (g == last) streak++;
            else begin last = g; streak = 1; end
            idx = maddr[g][5:2];
            if (mwmask[g] == 4'd0) begin
                pend = 1; pend_who = g; pend_data = shadow[idx];
            end else begin
                pend = 0;
                for (int b = 0; b < 4; b++)
                    if (mwmask[g][b]) shadow[idx][8*b +: 8] = mwdata[g][8*b +: 8];
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int g, gd;
        for (int i = 0; i < 16; i++) shadow[i] = init_word(i);
        for (int m = 0; m < 2; m++) begin
            mreq[m] = 0; maddr[m] = 0; mwdata[m] = 0; mwmask[m] = 0;
        end
        drive();
        @(posedge clk);
        #1;
        init_ram = 1'b0;

        // Requests during reset must not be granted.
        set_req(0, 32'h10, 32'd0, 4'd0);
        set_req(1, 32'h14, 32'h5, 4'hF);
        step(g, gd);
        step(g, gd);
        resetn = 1'b1;
        mreq[0] = 0; mreq[1] = 0;
        step(g, gd);

        // Single read of 0x10.
        set_req(0, 32'h10, 32'd0, 4'd0);
        step(g, gd);
        check("single_rd_gnt", 32'(gd), 32'd0);
        mreq[0] = 0;
        step(g, gd);

        // m1 byte write, then m0 reads it back.
        set_req(1, 32'h20, 32'h0000_00AB, 4'b0001);
        step(g, gd);
        mreq[1] = 0;
        set_req(0, 32'h20, 32'd0, 4'd0);
        step(g, gd);
        mreq[0] = 0;
        step(g, gd);

        // Contention right after reset.
        resetn = 1'b0;
        step(g, gd);
        resetn = 1'b1;
        new_req(0, 1);
        new_req(1, 1);
`ifdef ARB_FIXED_PRIO_EN
        for (int i = 0; i < 10; i++) begin
            step(g, gd);
            check("fixed_prio_m0", 32'(gd), 32'd0);
            new_req(0, 1);
        end
        mreq[0] = 0;
        step(g, gd);
        check("fixed_prio_m1", 32'(gd), 32'd1);
        mreq[1] = 0;
`else
        for (int i = 0; i < 20; i++) begin
            step(g, gd);
            check("burst_seq", 32'(gd), 32'((i / MAX_BURST) % 2));
            if (gd >= 0) new_req(gd, 1);
        end
        mreq[0] = 0; mreq[1] = 0;
`endif
        step(g, gd);

        // Alternating back-to-back reads.
        set_req(0, 32'h04, 32'd0, 4'd0);
        step(g, gd);
        mreq[0] = 0;
        set_req(1, 32'h08, 32'd0, 4'd0);
        step(g, gd);
        mreq[1] = 0;
        step(g, gd);

        // Reset the cycle after an m1 read is granted.
        set_req(1, 32'h30, 32'd0, 4'd0);
        step(g, gd);
        mreq[1] = 0;
        resetn = 1'b0;
        step(g, gd);
        resetn = 1'b1;
        new_req(0, 0);
        new_req(1, 0);
        step(g, gd);
        check("post_rst_first", 32'(gd), 32'd0);

        // Random traffic with holds, drops and occasional reset.
        for (int n = 0; n < 3000; n++) begin
            for (int m = 0; m < 2; m++) begin
                if (mreq[m] && gd == m) begin
                    if ($urandom_range(0, 3) != 0) new_req(m, 0);
                    else mreq[m] = 0;
                end else if (mreq[m]) begin
                    if ($urandom_range(0, 9) == 0) mreq[m] = 0;
                end else if ($urandom_range(0, 1) == 0) begin
                    new_req(m, 0);
                end
            end
            resetn = ($urandom_range(0, 199) != 0);
            step(g, gd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
